fft_config_sequencer: RTL and testbench

Parametrised AXI4-Stream configuration source for the FFT core's config channel. It replaces the single-word, single-shot initialiser with a multi-word sequence taken from a parameter table. It adds a runtime forward/inverse override, a programmable start delay, re-issue on request, and a compliant handshake: tvalid is held until accepted. It sits beside the FFT core on the video clock domain and drives its CONFIG_OUT slave port.

---
 rtl/fft_config_sequencer.sv | 147 ++++++++++++++
 tb/tb_fft_config_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_config_sequencer.sv
// AXI4-Stream config source: emits a NUM_WORDS-long table sequence with a runtime
// forward/inverse override, an optional delayed auto-start and request-driven re-issue.
module fft_config_sequencer #(
    parameter int CONFIG_WIDTH = 16,
    parameter int NUM_WORDS    = 4,
    parameter logic [NUM_WORDS*CONFIG_WIDTH-1:0] CONFIG_TABLE = '0,
    parameter int INV_BIT      = 0,
    parameter int START_DELAY  = 4,
    parameter int AUTO_START   = 1
) (
    input  logic                    s_axis_video_aclk,
    input  logic                    s_axis_video_aresetn,
    input  logic                    reconfig_req,
    input  logic                    inverse,
    output logic [CONFIG_WIDTH-1:0] CONFIG_OUT_tdata,
    output logic                    CONFIG_OUT_tvalid,
    input  logic                    CONFIG_OUT_tready,
    output logic                    CONFIG_OUT_tlast,
    output logic                    busy,
    output logic                    done
);

    localparam int IW = $clog2(NUM_WORDS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
    localparam logic [7:0]    DLY      = 8'(START_DELAY);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
    localparam state_t RST_STATE = (AUTO_START != 0) ? WAIT : IDLE;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    pend_q, pend_d;
    logic                    inv_q, inv_d;
    logic [CONFIG_WIDTH-1:0] tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [IW-1:0]           nxt_idx;
    logic                    hs;

    // Table word with the FWD_INV field forced from the latched direction (1 = forward).
    function automatic logic [CONFIG_WIDTH-1:0] word_at(input logic [IW-1:0] idx, input logic inv);
        logic [CONFIG_WIDTH-1:0] w;
        w          = CONFIG_TABLE[int'(idx)*CONFIG_WIDTH +: CONFIG_WIDTH];
        w[INV_BIT] = ~inv;
        return w;
    endfunction

    assign hs      = tvalid_q & CONFIG_OUT_tready;
    assign nxt_idx = idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        inv_d    = inv_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (reconfig_req || pend_q) begin
                    state_d  = SEND;
                    pend_d   = 1'b0;
                    inv_d    = inverse;
                    idx_d    = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = word_at('0, inverse);
                    tlast_d  = (LAST_IDX == '0);
                    busy_d   = 1'b1;
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                if (reconfig_req) pend_d = 1'b1;
                if (cnt_q == DLY) begin
                    state_d  = SEND;
                    inv_d    = inverse;
                    idx_d    = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = word_at('0, inverse);
                    tlast_d  = (LAST_IDX == '0);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SEND: begin
                if (reconfig_req) pend_d = 1'b1;
                if (hs) begin
                    if (tlast_q) begin
                        state_d  = IDLE;
                        idx_d    = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d   = nxt_idx;
                        tdata_d = word_at(nxt_idx, inv_q);
                        tlast_d = (nxt_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge s_axis_video_aclk or negedge s_axis_video_aresetn) begin
        if (!s_axis_video_aresetn) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            inv_q    <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            inv_q    <= inv_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign CONFIG_OUT_tdata  = tdata_q;
    assign CONFIG_OUT_tvalid = tvalid_q;
    assign CONFIG_OUT_tlast  = tlast_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_fft_config_sequencer.sv
// Bench for fft_config_sequencer: sequence-level reference model plus directed and random stimulus.
module tb_fft_config_sequencer;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, req = 1'b0, inv = 1'b0, tready = 1'b0;
    logic [15:0] tdata;
    logic        tvalid, tlast, busy, done;
    logic        rst2_n = 1'b0, req2 = 1'b0, tready2 = 1'b1;
    logic [15:0] tdata2;
    logic        tvalid2, tlast2, busy2, done2;

    always #5 clk = ~clk;

    fft_config_sequencer #(.CONFIG_WIDTH(16), .NUM_WORDS(3), .CONFIG_TABLE(48'h0300_0200_0101),
        .INV_BIT(0), .START_DELAY(SD), .AUTO_START(1)) dut (
        .s_axis_video_aclk(clk), .s_axis_video_aresetn(rst_n), .reconfig_req(req), .inverse(inv),
        .CONFIG_OUT_tdata(tdata), .CONFIG_OUT_tvalid(tvalid), .CONFIG_OUT_tready(tready),
        .CONFIG_OUT_tlast(tlast), .busy(busy), .done(done));

    fft_config_sequencer #(.CONFIG_WIDTH(16), .NUM_WORDS(3), .CONFIG_TABLE(48'h0300_0200_0101),
        .INV_BIT(0), .START_DELAY(SD), .AUTO_START(0)) dut2 (
        .s_axis_video_aclk(clk), .s_axis_video_aresetn(rst2_n), .reconfig_req(req2), .inverse(1'b0),
        .CONFIG_OUT_tdata(tdata2), .CONFIG_OUT_tvalid(tvalid2), .CONFIG_OUT_tready(tready2),
        .CONFIG_OUT_tlast(tlast2), .busy(busy2), .done(done2));

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sequence is a queue of expected words built when it starts.
    typedef enum int {M_IDLE, M_WAIT, M_SEND} mmode_t;
    mmode_t      mode;
    logic [15:0] expq[$];
    int          cnt;
    bit          pend, done_e, busy_known;
    logic [15:0] tbl [3] = '{16'h0101, 16'h0200, 16'h0300};

    function automatic logic [15:0] mword(input int i, input logic inv_);
        return (tbl[i] & 16'hFFFE) | {15'd0, ~inv_};
    endfunction

    task automatic mstart();
        mode = M_SEND;
        expq.delete();
        for (int i = 0; i < 3; i++) expq.push_back(mword(i, inv));
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = M_WAIT; expq.delete(); cnt = 0; pend = 0; done_e = 0; busy_known = 0;
        end else begin
            done_e = 0;
            busy_known = 1;
            case (mode)
                M_WAIT: begin
                    if (req) pend = 1;
                    if (cnt == SD) mstart(); else cnt++;
                end
                M_IDLE: if (req || pend) begin mstart(); pend = 0; end
                M_SEND: begin
                    if (req) pend = 1;
                    if (tready) begin
                        void'(expq.pop_front());
                        if (expq.size() == 0) begin mode = M_IDLE; done_e = 1; end
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_tvalid", tvalid, 0);
            chk("rst_tlast", tlast, 0);
            chk("rst_tdata", tdata, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end else begin
            chk("tvalid", tvalid, mode == M_SEND);
            if (mode == M_SEND && expq.size() > 0) begin
                chk("tdata", tdata, expq[0]);
                chk("tlast", tlast, expq.size() == 1);
            end
            chk("done", done, done_e);
            if (busy_known) chk("busy", busy, mode != M_IDLE);
        end
    end

    logic [15:0] log_q[$];
    int done_cnt = 0;
    always @(posedge clk) if (rst_n && tvalid && tready) log_q.push_back(tdata);
    always @(negedge clk) if (done) done_cnt++;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            if (done) ok = 1;
        end
        chk({"timeout_", name}, ok, 1);
    endtask

    task automatic check_log(input string name, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2);
        chk({name, "_count"}, log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk({name, "_w0"}, log_q[0], e0);
            chk({name, "_w1"}, log_q[1], e1);
            chk({name, "_w2"}, log_q[2], e2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dc0;
        bit pat [6] = '{0, 0, 1, 0, 1, 1};
        // Auto start after reset
        tready = 1; inv = 0;
        repeat (3) tick();
        log_q.delete();
        dc0 = done_cnt;
        rst_n = 1;
        for (n = 1; n <= 20; n++) begin
            tick();
            if (tvalid) break;
        end
        chk("first_valid_cycle", n, SD + 1);
        wait_done("auto", 10);
        check_log("auto", 16'h0101, 16'h0201, 16'h0301);
        tick();
        chk("auto_done_pulses", done_cnt - dc0, 1);

        // Back-pressure
        log_q.delete(); dc0 = done_cnt;
        tready = 0; req = 1; tick(); req = 0;
        for (int k = 0; k < 6; k++) begin tready = pat[k]; tick(); end
        tready = 1;
        repeat (2) tick();
        chk("bp_done_pulses", done_cnt - dc0, 1);
        check_log("bp", 16'h0101, 16'h0201, 16'h0301);

        // Inverse sampled at sequence start only
        log_q.delete();
        inv = 1; req = 1; tick(); req = 0;
        tick(); inv = 0;
        wait_done("inv", 10);
        check_log("inv", 16'h0100, 16'h0200, 16'h0300);
        tick();

        // Requests during busy collapse to one extra sequence
        log_q.delete(); dc0 = done_cnt;
        tready = 0; req = 1; tick();
        for (int k = 0; k < 3; k++) begin req = 0; tick(); req = 1; tick(); end
        req = 0; tready = 1;
        repeat (12) tick();
        chk("busyreq_done_pulses", done_cnt - dc0, 2);
        chk("busyreq_words", log_q.size(), 6);

        // Reset mid-sequence
        log_q.delete();
        tready = 1; req = 1; tick(); req = 0;
        chk("mid_w0", tdata, 16'h0101);
        req = 1; tick(); req = 0; tready = 0;
        chk("mid_w1", tdata, 16'h0201);
        rst_n = 0; #1;
        chk("async_tvalid", tvalid, 0);
        chk("async_tlast", tlast, 0);
        chk("async_done", done, 0);
        chk("async_busy", busy, 0);
        repeat (2) tick();
        log_q.delete(); dc0 = done_cnt;
        tready = 1; rst_n = 1;
        wait_done("restart", 20);
        check_log("restart", 16'h0101, 16'h0201, 16'h0301);
        repeat (8) tick();
        chk("restart_done_pulses", done_cnt - dc0, 1);

        // Randomised traffic against the model
        for (int k = 0; k < 1500; k++) begin
            tready = ($urandom_range(0, 9) < 7);
            req    = ($urandom_range(0, 19) == 0);
            inv    = 1'($urandom_range(0, 1));
            tick();
        end
        req = 0; tready = 1;
        repeat (20) tick();

        // AUTO_START=0 instance
        rst2_n = 1;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("noauto_tvalid", tvalid2, 0);
            chk("noauto_busy", busy2, 0);
        end
        req2 = 1; tick(); req2 = 0;
        chk("na_w0", {tvalid2, tlast2, tdata2}, {2'b10, 16'h0101});
        tick();
        chk("na_w1", {tvalid2, tlast2, tdata2}, {2'b10, 16'h0201});
        tick();
        chk("na_w2", {tvalid2, tlast2, tdata2}, {2'b11, 16'h0301});
        tick();
        chk("na_end", {tvalid2, busy2, done2}, 3'b001);
        tick();
        chk("na_idle", {tvalid2, busy2, done2}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
